// File: rtl/uart_tx_port.sv
// uart_tx_port: FIFO-buffered 8N1 UART transmitter with a memory-mapped status word.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit inserted, status[15]=1).
module uart_tx_port #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        clr_ovf,
    output logic [15:0] status,
    output logic        tx
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam int BW  = $clog2(CPB);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam state_t POST_DATA = PARITY;
    localparam logic   PAR_FLAG  = 1'b1;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam state_t POST_DATA = STOP;
    localparam logic   PAR_FLAG  = 1'b0;
`endif

    state_t        r_state;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_full, r_empty, r_ovf, r_tx;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit;
    logic [BW-1:0] r_baud;
    logic          w_push, w_pop, w_tick, w_last;
    logic [CW-1:0] w_count_nxt;
    logic [7:0]    w_head;
    logic          w_unused;

    assign w_tick      = (r_baud == BW'(CPB - 1));
    assign w_push      = wr_en && !r_full;
    assign w_pop       = !r_empty && (r_state == IDLE || (r_state == STOP && w_tick));
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_head      = r_mem[r_rptr];
    assign w_unused    = ^wr_data[15:8];
    assign status      = {PAR_FLAG, 9'b0, r_ovf, r_full, r_empty, r_state != IDLE, 2'b0};
    assign tx          = r_tx;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wr_data[7:0];
    end

    // An overflowing write beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_push);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
            r_empty <= (w_count_nxt == '0);
            r_ovf   <= (wr_en && r_full) || (r_ovf && !clr_ovf);
        end
    end

`ifdef UART_TX_PARITY_EN
    logic r_par;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_par <= 1'b0;
        else if (w_pop) r_par <= ^w_head;
    end
    assign w_last = r_par;
`else
    assign w_last = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_shift <= '0;
            r_bit   <= '0;
            r_baud  <= '0;
        end else begin
            r_baud <= (r_state == IDLE || w_tick) ? '0 : r_baud + BW'(1);
            case (r_state)
                IDLE: if (w_pop) begin
                    r_state <= START;
                    r_tx    <= 1'b0;
                    r_shift <= w_head;
                end
                START: if (w_tick) begin
                    r_state <= DATA;
                    r_bit   <= '0;
                    r_tx    <= r_shift[0];
                end
                DATA: if (w_tick) begin
                    r_shift <= {1'b0, r_shift[7:1]};
                    r_bit   <= r_bit + 3'd1;
                    r_tx    <= (r_bit == 3'd7) ? w_last : r_shift[1];
                    r_state <= (r_bit == 3'd7) ? POST_DATA : DATA;
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (w_tick) begin
                    r_state <= STOP;
                    r_tx    <= 1'b1;
                end
`endif
                STOP: if (w_tick) begin
                    r_state <= w_pop ? START : IDLE;
                    r_tx    <= !w_pop;
                    if (w_pop) r_shift <= w_head;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: randomized directed bench for uart_tx_port against a frame/occupancy model.
// Define UART_TX_PARITY_EN for both files to exercise 8E1 framing.
module tb_uart_tx_port;
    localparam int C     = 10;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int   FL  = 11;
    localparam logic PAR = 1'b1;
`else
    localparam int   FL  = 10;
    localparam logic PAR = 1'b0;
`endif
    localparam int FLC  = FL * C;
    localparam int LOGN = 20000;

    logic        clk = 1'b0, reset_n = 1'b0, wr_en = 1'b0, clr_ovf = 1'b0;
    logic [15:0] wr_data = '0;
    logic [15:0] status;
    logic        tx;
    int          checks = 0, failures = 0, edges = 0;
    logic        tx_log [LOGN];
    int          acc_t[$], pop_t[$];
    logic [7:0]  acc_b[$];
    logic        m_ovf = 1'b0;

    uart_tx_port #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
        .clr_ovf(clr_ovf), .status(status), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;
    // tx_log[n] holds the line value that follows clock edge n
    always @(negedge clk) if (edges < LOGN) tx_log[edges] = tx;

    initial begin
        #500000;
        $display("FAIL watchdog expired at edge %0d", edges);
        $fatal(1, "watchdog");
    end

    function automatic int m_cnt(int e, bit incl);
        int n = 0;
        foreach (acc_t[k]) n += (incl ? acc_t[k] <= e : acc_t[k] < e) ? 1 : 0;
        foreach (pop_t[k]) n -= (incl ? pop_t[k] <= e : pop_t[k] < e) ? 1 : 0;
        return n;
    endfunction

    function automatic logic [15:0] m_status(int e);
        int   n    = m_cnt(e, 1'b1);
        logic busy = 1'b0;
        foreach (pop_t[k]) if (pop_t[k] <= e && e < pop_t[k] + FLC) busy = 1'b1;
        return {PAR, 9'b0, m_ovf, n == DEPTH, n == 0, busy, 2'b0};
    endfunction

    function automatic logic [127:0] frame_bits(logic [7:0] b);
        logic [127:0] v = '1;
        for (int j = 0; j < FLC; j++) begin
            int p = j / C;
            v[j] = (p == 0) ? 1'b0 : (p <= 8) ? b[p-1] : (p == 9 && FL == 11) ? ^b : 1'b1;
        end
        return v;
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_status(string tag);
        chk(tag, 128'(status), 128'(m_status(edges)));
    endtask

    // A write lands on the next edge; the byte starts its frame one edge later or when the line frees.
    task automatic wr(logic [15:0] d, logic clr);
        int e    = edges + 1;
        bit drop = (m_cnt(e, 1'b0) == DEPTH);
        wr_en   = 1'b1;
        wr_data = d;
        clr_ovf = clr;
        if (!drop) begin
            acc_t.push_back(e);
            acc_b.push_back(d[7:0]);
            pop_t.push_back((pop_t.size() == 0) ? e + 1 :
                            (pop_t[$] + FLC > e + 1) ? pop_t[$] + FLC : e + 1);
        end
        m_ovf = drop | (m_ovf & ~clr);
        step(1);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic clr();
        clr_ovf = 1'b1;
        m_ovf   = 1'b0;
        step(1);
        clr_ovf = 1'b0;
    endtask

    task automatic drain(string tag);
        int fin = (pop_t.size() != 0) ? pop_t[$] + FLC : edges;
        while (edges <= fin) step(1);
        chk_status({tag, "_status"});
        foreach (pop_t[k]) begin
            logic [127:0] obs = '1;
            for (int j = 0; j < FLC; j++) obs[j] = tx_log[pop_t[k] + j];
            chk($sformatf("%s_frame%0d", tag, k), obs, frame_bits(acc_b[k]));
        end
        if (pop_t.size() != 0) begin
            chk({tag, "_pre_idle"}, 128'(tx_log[pop_t[0] - 1]), 128'(1));
            chk({tag, "_post_idle"}, 128'(tx_log[fin]), 128'(1));
        end
        acc_t.delete();
        acc_b.delete();
        pop_t.delete();
    endtask

    initial begin
        int n, p;
        step(3);
        chk("reset_tx", 128'(tx), 128'(1));
        chk("reset_status", 128'(status), 128'({PAR, 15'h0008}));
        reset_n = 1'b1;
        step(2);
        chk_status("idle_status");

        wr(16'hAB55, 1'b0);
        chk_status("single_queued");
        chk("single_still_idle", 128'(tx), 128'(1));
        step(1);
        chk("single_start", 128'(tx), 128'(0));
        drain("single");

        wr(16'h0001, 1'b0);
        wr(16'h0002, 1'b0);
        wr(16'h0003, 1'b0);
        chk_status("b2b_queued");
        while (edges < pop_t[2]) step(1);
        chk_status("b2b_last_pop");
        drain("b2b");

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                wr(16'($urandom), $urandom_range(0, 3) == 0);
                chk_status($sformatf("rnd%0d_w%0d", r, i));
                step($urandom_range(0, 40));
            end
            drain($sformatf("rnd%0d", r));
        end

        clr();
        chk_status("ovf_pre_clear");
        for (int i = 0; i < 6; i++) wr(16'($urandom), 1'b0);
        chk_status("ovf_full");
        wr(16'($urandom), 1'b1);
        chk_status("ovf_set_wins");
        clr();
        chk_status("ovf_cleared");
        drain("ovf");

        wr(16'h5A07, 1'b0);
        step(1);
        chk_status("par_busy");
        drain("par");

        wr(16'($urandom) & 16'hFFF7, 1'b0);
        wr(16'($urandom), 1'b0);
        p = pop_t[0];
        while (edges < p + 4 * C + 3) step(1);
        chk("rst_pre_tx", 128'(tx), 128'(0));
        #2 reset_n = 1'b0;
        #1;
        chk("rst_tx_async", 128'(tx), 128'(1));
        chk("rst_status_async", 128'(status), 128'({PAR, 15'h0008}));
        acc_t.delete();
        acc_b.delete();
        pop_t.delete();
        m_ovf = 1'b0;
        step(2);
        reset_n = 1'b1;
        p = edges;
        step(3 * FLC);
        n = 0;
        for (int j = p; j < edges; j++) n += (tx_log[j] !== 1'b1) ? 1 : 0;
        chk("rst_no_residual", 128'(n), 128'(0));
        chk_status("rst_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
